// File: rtl/pulse_stretcher_mc.sv
// pulse_stretcher_mc: multi-channel rising-edge pulse stretcher with per-channel delay and width.
// Sticky missed-trigger flags are built only when PULSE_STRETCH_MISSED_EN is defined.
module pulse_stretcher_mc #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       trigger,
  input  logic [CHANNELS*CNT_W-1:0] delay_cfg,
  input  logic [CHANNELS*CNT_W-1:0] width_cfg,
  input  logic [CHANNELS-1:0]       retrig,
  input  logic                      clr_missed,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       missed
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CHANNELS-1:0] trig_q, trig_d;
  logic [CHANNELS-1:0] trig_edge;
  logic [CHANNELS-1:0] miss_evt;

  // A programmed width of zero still produces a one-cycle pulse.
  function automatic logic [CNT_W-1:0] eff_width(input logic [CNT_W-1:0] w);
    return (w == '0) ? CNT_ONE : w;
  endfunction

  always_comb begin
    trig_d    = trigger;
    trig_edge = trigger & ~trig_q;
  end

  // Resetting to ones keeps a trigger held high across reset release from firing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= '1;
    end else begin
      trig_q <= trig_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_sh_q, width_sh_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] dly_cfg, wid_cfg;
    logic             ch_edge, ch_retrig;
    logic             miss_ch;

    assign dly_cfg   = delay_cfg[g*CNT_W +: CNT_W];
    assign wid_cfg   = width_cfg[g*CNT_W +: CNT_W];
    assign ch_edge   = trig_edge[g];
    assign ch_retrig = retrig[g];

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      width_sh_d = width_sh_q;
      miss_ch    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ch_edge) begin
            width_sh_d = wid_cfg;
            if (dly_cfg == '0) begin
              cnt_d   = eff_width(wid_cfg);
              state_d = ST_PULSE;
            end else begin
              cnt_d   = dly_cfg;
              state_d = ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          miss_ch = ch_edge & ~ch_retrig;
          if (cnt_q == CNT_ONE) begin
            cnt_d   = eff_width(width_sh_q);
            state_d = ST_PULSE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_PULSE: begin
          // A retrigger restarts the width count using the live width setting.
          if (ch_edge && ch_retrig) begin
            cnt_d = eff_width(wid_cfg);
          end else begin
            miss_ch = ch_edge;
            if (cnt_q == CNT_ONE) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
      pulse_d = (state_d == ST_PULSE);
      busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        width_sh_q <= '0;
        pulse_q    <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        width_sh_q <= width_sh_d;
        pulse_q    <= pulse_d;
        busy_q     <= busy_d;
      end
    end

    assign pulse_out[g] = pulse_q;
    assign busy[g]      = busy_q;
    assign miss_evt[g]  = miss_ch;
  end

`ifdef PULSE_STRETCH_MISSED_EN
  logic [CHANNELS-1:0] missed_q, missed_d;

  // A miss in the same cycle as a clear keeps the flag set.
  always_comb begin
    missed_d = (clr_missed ? '0 : missed_q) | miss_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      missed_q <= '0;
    end else begin
      missed_q <= missed_d;
    end
  end

  assign missed = missed_q;
`else
  logic unused_missed_inputs;
  assign unused_missed_inputs = clr_missed | (|miss_evt);
  assign missed = '0;
`endif

endmodule
